// File: rtl/servo_pwm_decoder.sv
// rtl/servo_pwm_decoder.sv - servo PWM pulse-width measurement and angle recovery
module servo_pwm_decoder #(
  parameter int MIN_COUNT     = 25000,
  parameter int MAX_COUNT     = 50000,
  parameter int REJECT_LO     = 12500,
  parameter int REJECT_HI     = 62500,
  parameter int TIMEOUT_COUNT = 1000000
) (
  input  logic        i_Clk,
  input  logic        clr,
  input  logic        i_Pwm,
  output logic [8:0]  o_Angle,
  output logic        o_Valid,
  output logic [19:0] o_Pulse_Width,
  output logic        o_Error,
  output logic        o_Timeout
);

  localparam logic [19:0] MIN_W = 20'(MIN_COUNT);
  localparam logic [19:0] MAX_W = 20'(MAX_COUNT);
  localparam logic [19:0] LO_W  = 20'(REJECT_LO);
  localparam logic [19:0] HI_W  = 20'(REJECT_HI);
  localparam logic [19:0] TO_W  = 20'(TIMEOUT_COUNT);
  // Divisor pre-shifted to line up with the most significant quotient bit.
  localparam logic [31:0] SPAN_SH = 32'(MAX_COUNT - MIN_COUNT) << 8;

  typedef enum logic [2:0] {WAIT_LOW, WAIT_RISE, HIGH, CHECK, DIVIDE} state_t;

  state_t      state;
  logic        sync_a, s, s_d;
  logic        rise, fall;
  logic [19:0] w;
  logic [19:0] idle_cnt;
  logic [19:0] wc;
  logic [31:0] offset;
  logic [22:0] dividend;
  logic [22:0] rem;
  logic [31:0] dsh;
  logic [8:0]  quo;
  logic [3:0]  step;
  logic        ge;

  // Two-flop synchronizer plus delay tap; reset to "high" so a line that is
  // already high at reset release never looks like a fresh rising edge.
  always_ff @(posedge i_Clk) begin
    if (clr) begin
      sync_a <= 1'b1;
      s      <= 1'b1;
      s_d    <= 1'b1;
    end else begin
      sync_a <= i_Pwm;
      s      <= sync_a;
      s_d    <= s;
    end
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // Idle counter: cycles since the last rising edge, saturating at the limit.
  always_ff @(posedge i_Clk) begin
    if (clr || rise) begin
      idle_cnt <= '0;
    end else if (idle_cnt != TO_W) begin
      idle_cnt <= idle_cnt + 20'd1;
    end
  end

  assign o_Timeout = (idle_cnt == TO_W);

  // Clamp the width into the mapped range and scale by 180 (128+32+16+4).
  always_comb begin
    wc = w;
    if (w < MIN_W) begin
      wc = MIN_W;
    end else if (w > MAX_W) begin
      wc = MAX_W;
    end
    offset   = 32'(wc - MIN_W);
    dividend = 23'((offset << 7) + (offset << 5) + (offset << 4) + (offset << 2));
    ge       = ({9'd0, rem} >= dsh);
  end

  // Measurement FSM: width capture, range check, restoring divide, result.
  always_ff @(posedge i_Clk) begin
    if (clr) begin
      state         <= WAIT_LOW;
      w             <= '0;
      rem           <= '0;
      dsh           <= '0;
      quo           <= '0;
      step          <= '0;
      o_Angle       <= '0;
      o_Pulse_Width <= '0;
      o_Valid       <= 1'b0;
      o_Error       <= 1'b0;
    end else begin
      o_Valid <= 1'b0;
      o_Error <= 1'b0;
      case (state)
        WAIT_LOW: begin
          if (!s) state <= WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise) begin
            w     <= 20'd1;
            state <= HIGH;
          end
        end
        HIGH: begin
          // Stuck-high guard is checked first so w stops at REJECT_HI + 1.
          if (w > HI_W) begin
            o_Error <= 1'b1;
            state   <= WAIT_LOW;
          end else if (fall) begin
            state <= CHECK;
          end else if (s) begin
            w <= w + 20'd1;
          end
        end
        CHECK: begin
          if (w < LO_W || w > HI_W) begin
            o_Error <= 1'b1;
            state   <= WAIT_RISE;
          end else begin
            rem   <= dividend;
            dsh   <= SPAN_SH;
            quo   <= '0;
            step  <= '0;
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (step == 4'd9) begin
            o_Angle       <= quo;
            o_Pulse_Width <= w;
            o_Valid       <= 1'b1;
            state         <= WAIT_RISE;
          end else begin
            if (ge) rem <= rem - dsh[22:0];
            quo  <= {quo[7:0], ge};
            dsh  <= dsh >> 1;
            step <= step + 4'd1;
          end
        end
        default: state <= WAIT_LOW;
      endcase
    end
  end

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb/tb_servo_pwm_decoder.sv - self-checking bench for servo_pwm_decoder
module tb_servo_pwm_decoder;

  localparam int MINC = 250;
  localparam int MAXC = 500;
  localparam int RLO  = 125;
  localparam int RHI  = 625;
  localparam int TOC  = 3000;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        pwm = 1'b0;
  logic [8:0]  angle;
  logic        valid;
  logic [19:0] pulse_width;
  logic        error;
  logic        timeout;

  servo_pwm_decoder #(
    .MIN_COUNT(MINC), .MAX_COUNT(MAXC), .REJECT_LO(RLO),
    .REJECT_HI(RHI), .TIMEOUT_COUNT(TOC)
  ) dut (
    .i_Clk(clk), .clr(clr), .i_Pwm(pwm),
    .o_Angle(angle), .o_Valid(valid), .o_Pulse_Width(pulse_width),
    .o_Error(error), .o_Timeout(timeout)
  );

  always #20 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  typedef struct {
    int e;
    int kind;   // 0 = valid result, 1 = error
    int ang;
    int pw;
  } ev_t;

  ev_t evq[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  m_angle = 0;
  int  m_pw = 0;
  int  base = 0;
  int  pend_base = -1;
  bit  in_rst = 1'b1;

  function automatic int model_angle(int width);
    int c;
    c = (width < MINC) ? MINC : ((width > MAXC) ? MAXC : width);
    return ((c - MINC) * 180) / (MAXC - MINC);
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s at edge %0d: got %0d, wanted %0d", name, edge_n, act, exp);
    end
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic tick();
    int ev_v;
    int ev_e;
    @(negedge clk);
    ev_v = 0;
    ev_e = 0;
    if (in_rst) begin
      evq.delete();
      m_angle   = 0;
      m_pw      = 0;
      base      = edge_n;
      pend_base = -1;
    end
    if (pend_base >= 0 && edge_n >= pend_base) begin
      base      = pend_base;
      pend_base = -1;
    end
    if (evq.size() > 0 && evq[0].e < edge_n) begin
      chk("event_lost", evq[0].e, edge_n);
      void'(evq.pop_front());
    end
    if (evq.size() > 0 && evq[0].e == edge_n) begin
      if (evq[0].kind == 0) begin
        ev_v    = 1;
        m_angle = evq[0].ang;
        m_pw    = evq[0].pw;
      end else begin
        ev_e = 1;
      end
      void'(evq.pop_front());
    end
    chk("valid", int'(valid), ev_v);
    chk("error", int'(error), ev_e);
    chk("angle", int'(angle), m_angle);
    chk("pulse_width", int'(pulse_width), m_pw);
    chk("timeout", int'(timeout), ((edge_n - base) >= TOC) ? 1 : 0);
  endtask

  // Drive an n-cycle clock-aligned high pulse, then gap cycles low.
  task automatic pulse(int n, int gap);
    int   r0;
    int   f0;
    ev_t  ev;
    r0 = edge_n + 1;
    f0 = r0 + n;
    pwm = 1'b1;
    pend_base = r0 + 2;
    if (n > RHI) begin
      ev = '{e: r0 + RHI + 3, kind: 1, ang: 0, pw: 0};
    end else if (n < RLO) begin
      ev = '{e: f0 + 3, kind: 1, ang: 0, pw: 0};
    end else begin
      ev = '{e: f0 + 13, kind: 0, ang: model_angle(n), pw: n};
    end
    evq.push_back(ev);
    repeat (n) tick();
    pwm = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic do_reset(int cycles);
    clr = 1'b1;
    in_rst = 1'b1;
    repeat (cycles) tick();
    clr = 1'b0;
    in_rst = 1'b0;
  endtask

  initial begin
    repeat (4) tick();
    chk("rst_angle", int'(angle), 0);
    chk("rst_pw", int'(pulse_width), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    clr = 1'b0;
    in_rst = 1'b0;
    repeat (20) tick();

    pulse(375, 100);
    chk("lit_angle_375", int'(angle), 90);
    chk("lit_pw_375", int'(pulse_width), 375);
    pulse(250, 60);
    chk("lit_angle_250", int'(angle), 0);
    pulse(500, 60);
    chk("lit_angle_500", int'(angle), 180);
    pulse(450, 60);
    chk("lit_angle_450", int'(angle), 144);
    pulse(333, 60);
    chk("lit_angle_333", int'(angle), 59);
    pulse(200, 60);
    chk("lit_angle_200", int'(angle), 0);
    chk("lit_pw_200", int'(pulse_width), 200);
    pulse(550, 60);
    chk("lit_angle_550", int'(angle), 180);
    chk("lit_pw_550", int'(pulse_width), 550);
    pulse(333, 60);
    pulse(100, 60);
    chk("lit_angle_hold", int'(angle), 59);
    pulse(800, 60);
    chk("lit_angle_stuck", int'(angle), 59);

    repeat (TOC + 100) tick();
    chk("lit_timeout_set", int'(timeout), 1);
    pulse(375, 60);
    chk("lit_timeout_clr", int'(timeout), 0);
    chk("lit_angle_after_to", int'(angle), 90);

    // Line already high when reset releases: partial pulse must be ignored.
    pwm = 1'b1;
    do_reset(4);
    repeat (100) tick();
    pwm = 1'b0;
    repeat (60) tick();
    chk("lit_partial_ignored", int'(angle), 0);
    pulse(375, 60);
    chk("lit_angle_post_partial", int'(angle), 90);

    // Reset asserted in the middle of a pulse.
    pulse(450, 60);
    pwm = 1'b1;
    pend_base = edge_n + 3;
    repeat (100) tick();
    do_reset(4);
    repeat (100) tick();
    pwm = 1'b0;
    repeat (60) tick();
    chk("lit_midpulse_ignored", int'(angle), 0);
    pulse(375, 60);
    chk("lit_angle_post_mid", int'(angle), 90);
    chk("events_drained", evq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
